cache_data_array: RTL and testbench

//  Set-associative cache data store: WAYS x SETS lines of WORDS words each, with byte-strobe
//  CPU writes, registered line reads, and a word-serial refill engine that loads one line
//  per burst from the memory side. Sits between the cache controller (hit/miss, way select)
//  and the AXI read channel that returns refill beats.

---
 rtl/cache_data_array_pkg.sv | 26 ++
 rtl/cache_data_bank.sv | 44 ++++
 rtl/cache_data_array.sv | 170 +++++++++++++++++
 tb/tb_cache_data_array.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_data_array_pkg.sv
// cache_data_array_pkg
//   Shared definitions for the cache data store: default geometry, refill
//   FSM state encoding and a width helper used for derived widths.
package cache_data_array_pkg;

  localparam int WAYS_DEF   = 2;
  localparam int SETS_DEF   = 16;
  localparam int WORDS_DEF  = 4;
  localparam int WORD_W_DEF = 32;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

  // log2 that never returns 0, so single-entry dimensions still get a 1-bit field
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W_DEF  = clog2_min1(SETS_DEF);
  localparam int OFF_W_DEF  = clog2_min1(WORDS_DEF);
  localparam int LINE_W_DEF = WORDS_DEF * WORD_W_DEF;
  localparam int STRB_W_DEF = LINE_W_DEF / 8;

endpackage

// File: rtl/cache_data_bank.sv
// cache_data_bank
//   One way of the data store: SETS lines of WORDS words. Combinational line
//   read, single byte-masked write port spanning the whole line (a refill beat
//   is a write whose mask covers one word). Synchronous clear on reset.
// Ports
//   clk, rst_n   clock, synchronous active-low reset (clears storage)
//   i_rd_index   line to read;   o_rd_line  its current content
//   i_wr_en      write strobe;   i_wr_index target line
//   i_wr_data    write line;     i_wr_strb  byte enables over the line
module cache_data_bank
  import cache_data_array_pkg::*;
#(
  parameter int SETS   = SETS_DEF,
  parameter int WORDS  = WORDS_DEF,
  parameter int WORD_W = WORD_W_DEF,
  localparam int IDX_W  = clog2_min1(SETS),
  localparam int LINE_W = WORDS * WORD_W,
  localparam int STRB_W = LINE_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  i_rd_index,
  output logic [LINE_W-1:0] o_rd_line,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_index,
  input  logic [LINE_W-1:0] i_wr_data,
  input  logic [STRB_W-1:0] i_wr_strb
);

  logic [SETS-1:0][LINE_W-1:0] r_mem;

  assign o_rd_line = r_mem[i_rd_index];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem <= '0;
    end else if (i_wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (i_wr_strb[b]) r_mem[i_wr_index][8*b +: 8] <= i_wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/cache_data_array.sv
// cache_data_array
//   Set-associative cache data store with CPU line access and a word-serial
//   refill engine. CPU requests are taken only while IDLE; each accepted
//   request returns the pre-write line one cycle later. A refill latches
//   way/index on fill_start, then writes one word per accepted beat.
// Ports
//   clk, rst_n                        clock, synchronous active-low reset
//   req_valid/req_ready               CPU request handshake
//   req_we/req_way/req_index          access type and target line
//   req_wdata/req_strb                write line and byte enables
//   rsp_valid/rsp_data                1-cycle response pulse, old line content
//   fill_start/fill_way/fill_index    begin refill of a line
//   fill_valid/fill_ready/fill_data   refill beat handshake
//   fill_done                         pulse the cycle after the last beat
module cache_data_array
  import cache_data_array_pkg::*;
#(
  parameter int WAYS   = WAYS_DEF,
  parameter int SETS   = SETS_DEF,
  parameter int WORDS  = WORDS_DEF,
  parameter int WORD_W = WORD_W_DEF,
  localparam int WAY_W  = clog2_min1(WAYS),
  localparam int IDX_W  = clog2_min1(SETS),
  localparam int OFF_W  = clog2_min1(WORDS),
  localparam int LINE_W = WORDS * WORD_W,
  localparam int STRB_W = LINE_W / 8,
  localparam int WSTRB  = WORD_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WAY_W-1:0]  req_way,
  input  logic [IDX_W-1:0]  req_index,
  input  logic [LINE_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_strb,
  output logic              rsp_valid,
  output logic [LINE_W-1:0] rsp_data,
  input  logic              fill_start,
  input  logic [WAY_W-1:0]  fill_way,
  input  logic [IDX_W-1:0]  fill_index,
  input  logic              fill_valid,
  output logic              fill_ready,
  input  logic [WORD_W-1:0] fill_data,
  output logic              fill_done
);

  fill_state_e r_state, w_state_nxt;
  logic [OFF_W-1:0] r_beat_cnt;
  logic [WAY_W-1:0] r_fill_way;
  logic [IDX_W-1:0] r_fill_index;
  logic             r_rsp_valid;
  logic [LINE_W-1:0] r_rsp_data;
  logic             r_fill_done;

  logic w_req_ready, w_fill_ready;
  logic w_req_fire, w_beat_fire, w_last_beat;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_req_ready  = 1'b0;
    w_fill_ready = 1'b0;
    case (r_state)
      IDLE: begin
        w_req_ready = 1'b1;
        if (fill_start) w_state_nxt = FILL;
      end
      FILL: begin
        w_fill_ready = 1'b1;
        if (fill_valid && w_last_beat) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshakes are held low while reset is asserted so nothing looks accepted.
  assign req_ready  = w_req_ready  & rst_n;
  assign fill_ready = w_fill_ready & rst_n;

  assign w_req_fire  = req_valid  & req_ready;
  assign w_beat_fire = fill_valid & fill_ready;
  assign w_last_beat = (r_beat_cnt == OFF_W'(WORDS - 1));

  // ---------------- refill bookkeeping ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_beat_cnt   <= '0;
      r_fill_way   <= '0;
      r_fill_index <= '0;
      r_fill_done  <= 1'b0;
    end else begin
      r_fill_done <= w_beat_fire & w_last_beat;
      if (r_state == IDLE && fill_start) begin
        r_fill_way   <= fill_way;
        r_fill_index <= fill_index;
        r_beat_cnt   <= '0;
      end else if (w_beat_fire) begin
        // Wraps to 0 on the last beat, so the next refill starts clean.
        r_beat_cnt <= (w_last_beat) ? '0 : r_beat_cnt + 1'b1;
      end
    end
  end

  // ---------------- bank write port ----------------
  // CPU writes and refill beats never coincide: requests are only accepted
  // in IDLE and beats only in FILL, so one shared port per bank suffices.
  logic [IDX_W-1:0]  w_wr_index;
  logic [LINE_W-1:0] w_wr_data;
  logic [STRB_W-1:0] w_wr_strb;
  logic [STRB_W-1:0] w_beat_strb;

  always_comb begin
    w_beat_strb = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (r_beat_cnt == OFF_W'(w)) w_beat_strb[w*WSTRB +: WSTRB] = '1;
    end
  end

  assign w_wr_index = (r_state == FILL) ? r_fill_index : req_index;
  assign w_wr_data  = (r_state == FILL) ? {WORDS{fill_data}} : req_wdata;
  assign w_wr_strb  = (r_state == FILL) ? w_beat_strb : req_strb;

  // ---------------- banks ----------------
  logic [WAYS-1:0][LINE_W-1:0] w_rd_line;
  logic [WAYS-1:0]             w_wr_en;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    assign w_wr_en[g] = (w_req_fire  & req_we & (req_way    == WAY_W'(g))) |
                        (w_beat_fire &          (r_fill_way == WAY_W'(g)));

    cache_data_bank #(
      .SETS   (SETS),
      .WORDS  (WORDS),
      .WORD_W (WORD_W)
    ) u_bank (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_rd_index (req_index),
      .o_rd_line  (w_rd_line[g]),
      .i_wr_en    (w_wr_en[g]),
      .i_wr_index (w_wr_index),
      .i_wr_data  (w_wr_data),
      .i_wr_strb  (w_wr_strb)
    );
  end

  // ---------------- response ----------------
  // Captures the line as it stands before this cycle's write lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= w_req_fire;
      if (w_req_fire) r_rsp_data <= w_rd_line[req_way];
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign fill_done = r_fill_done;

endmodule

// File: tb/tb_cache_data_array.sv
module tb_cache_data_array;

  localparam int WAYS = 2, SETS = 16, WORDS = 4, WORD_W = 32;
  localparam int LINE_W = WORDS * WORD_W, STRB_W = LINE_W / 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_we;
  logic [0:0]        req_way;
  logic [3:0]        req_index;
  logic [LINE_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_strb;
  logic              rsp_valid;
  logic [LINE_W-1:0] rsp_data;
  logic              fill_start, fill_valid, fill_ready, fill_done;
  logic [0:0]        fill_way;
  logic [3:0]        fill_index;
  logic [WORD_W-1:0] fill_data;

  always #5 clk = ~clk;

  cache_data_array dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_way(req_way), .req_index(req_index), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .fill_start(fill_start), .fill_way(fill_way), .fill_index(fill_index),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_data(fill_data),
    .fill_done(fill_done)
  );

  // Reference: plain array of lines, byte-granular merge.
  logic [LINE_W-1:0] mdl [WAYS][SETS];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] merge(input logic [LINE_W-1:0] old,
                                             input logic [LINE_W-1:0] wd,
                                             input logic [STRB_W-1:0] st);
    logic [LINE_W-1:0] r;
    r = old;
    for (int b = 0; b < STRB_W; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [LINE_W-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic clear_model();
    for (int w = 0; w < WAYS; w++) for (int s = 0; s < SETS; s++) mdl[w][s] = '0;
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_we = 0; req_way = 0; req_index = 0; req_wdata = '0; req_strb = '0;
    fill_start = 0; fill_way = 0; fill_index = 0; fill_valid = 0; fill_data = '0;
  endtask

  task automatic do_req(input bit we, input int way, input int idx,
                        input logic [LINE_W-1:0] wd, input logic [STRB_W-1:0] st,
                        input string tag);
    logic [LINE_W-1:0] exp;
    @(negedge clk);
    check({tag, ".ready"}, req_ready, 1);
    req_valid = 1; req_we = we; req_way = way[0:0]; req_index = idx[3:0];
    req_wdata = wd; req_strb = st;
    exp = mdl[way][idx];
    if (we) mdl[way][idx] = merge(mdl[way][idx], wd, st);
    @(posedge clk); #1;
    req_valid = 0; req_we = 0;
    check({tag, ".rsp_valid"}, rsp_valid, 1);
    check({tag, ".rsp_data"}, rsp_data, exp);
  endtask

  // Write then read the same line on consecutive cycles.
  task automatic b2b(input int way, input int idx, input logic [LINE_W-1:0] wd,
                     input logic [STRB_W-1:0] st);
    logic [LINE_W-1:0] old;
    @(negedge clk);
    old = mdl[way][idx];
    mdl[way][idx] = merge(old, wd, st);
    req_valid = 1; req_we = 1; req_way = way[0:0]; req_index = idx[3:0];
    req_wdata = wd; req_strb = st;
    @(posedge clk); #1;
    req_we = 0;
    check("b2b.wr_rsp_valid", rsp_valid, 1);
    check("b2b.wr_rsp_data", rsp_data, old);
    @(posedge clk); #1;
    req_valid = 0;
    check("b2b.rd_rsp_valid", rsp_valid, 1);
    check("b2b.rd_rsp_data", rsp_data, mdl[way][idx]);
  endtask

  // Refill a line with random gaps; optional stray fill_start during FILL and
  // optional read issued in the fill_start cycle.
  task automatic do_fill(input int way, input int idx, input logic [WORD_W-1:0] d0,
                         input logic [WORD_W-1:0] d1, input logic [WORD_W-1:0] d2,
                         input logic [WORD_W-1:0] d3, input bit stray, input bit with_rd);
    logic [WORD_W-1:0] d [WORDS];
    logic [LINE_W-1:0] exp_rd;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    @(negedge clk);
    fill_start = 1; fill_way = way[0:0]; fill_index = idx[3:0];
    exp_rd = mdl[1-way][idx];
    if (with_rd) begin
      req_valid = 1; req_we = 0; req_way = 1 - way[0:0]; req_index = idx[3:0];
    end
    @(posedge clk); #1;
    fill_start = 0; req_valid = 0;
    if (with_rd) begin
      check("fill.simul_rsp_valid", rsp_valid, 1);
      check("fill.simul_rsp_data", rsp_data, exp_rd);
    end
    for (int k = 0; k < WORDS; k++) begin
      int gaps;
      gaps = (k % 2) + $urandom_range(0, 1);
      for (int g = 0; g < gaps; g++) begin
        check("fill.gap_req_ready", req_ready, 0);
        check("fill.gap_fill_done", fill_done, 0);
        if (stray) begin
          fill_start = 1; fill_way = 1 - way[0:0]; fill_index = idx[3:0] + 4'd1;
        end
        @(posedge clk); #1;
        fill_start = 0;
      end
      check("fill.fill_ready", fill_ready, 1);
      check("fill.req_ready", req_ready, 0);
      fill_valid = 1; fill_data = d[k];
      mdl[way][idx][k*WORD_W +: WORD_W] = d[k];
      @(posedge clk); #1;
      fill_valid = 0;
      if (k < WORDS - 1) check("fill.early_done", fill_done, 0);
    end
    check("fill.done_pulse", fill_done, 1);
    check("fill.ready_after", req_ready, 1);
    check("fill.fill_ready_after", fill_ready, 0);
    @(posedge clk); #1;
    check("fill.done_clear", fill_done, 0);
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    clear_model();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst.req_ready", req_ready, 0);
    check("rst.rsp_valid", rsp_valid, 0);
    check("rst.rsp_data", rsp_data, '0);
    check("rst.fill_ready", fill_ready, 0);
    check("rst.fill_done", fill_done, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    check("rst.req_ready_after", req_ready, 1);
    check("rst.rsp_valid_idle", rsp_valid, 0);

    // Read of untouched line returns zero
    do_req(0, 1, 5, '0, '0, "rd_w1s5");
    check("rd_w1s5.zero", rsp_data, '0);

    // Strobed write
    do_req(1, 0, 3, 128'h44444444_33333333_22222222_11111111, 16'h00F3, "strb_wr");
    do_req(0, 0, 3, '0, '0, "strb_rd");
    check("strb.const", rsp_data, 128'h00000000_00000000_22222222_00001111);

    // All-zero strobe leaves line untouched
    do_req(1, 0, 3, '1, '0, "zstrb_wr");
    do_req(0, 0, 3, '0, '0, "zstrb_rd");
    check("zstrb.const", rsp_data, 128'h00000000_00000000_22222222_00001111);

    // Refill with gaps and stray fill_start
    do_fill(1, 7, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 1, 0);
    do_req(0, 1, 7, '0, '0, "fill_rd");
    check("fill.const", rsp_data, 128'h000000A3_000000A2_000000A1_000000A0);
    do_req(0, 0, 8, '0, '0, "stray_target");  // stray target line untouched

    // fill_valid in IDLE ignored
    @(negedge clk); fill_valid = 1; fill_data = 32'hDEADBEEF;
    @(posedge clk); #1; fill_valid = 0;
    check("idle_beat.no_done", fill_done, 0);
    do_req(0, 1, 7, '0, '0, "idle_beat_rd");

    // Back-to-back write then read
    b2b(1, 9, rnd_line(), 16'hFFFF);
    b2b(0, 9, rnd_line(), 16'h0F0F);

    // Same set, different ways: no aliasing
    do_req(1, 0, 12, {4{32'h0000_AAAA}}, '1, "alias_w0");
    do_req(1, 1, 12, {4{32'h5555_0000}}, '1, "alias_w1");
    do_req(0, 0, 12, '0, '0, "alias_r0");
    check("alias.w0", rsp_data, {4{32'h0000_AAAA}});
    do_req(0, 1, 12, '0, '0, "alias_r1");
    check("alias.w1", rsp_data, {4{32'h5555_0000}});

    // fill_start together with an accepted read
    do_fill(0, 12, $urandom, $urandom, $urandom, $urandom, 0, 1);
    do_req(0, 0, 12, '0, '0, "simul_rd");

    // Randomized traffic against the model
    for (int i = 0; i < 150; i++) begin
      int op, w, s;
      op = $urandom_range(0, 9);
      w  = $urandom_range(0, WAYS - 1);
      s  = $urandom_range(0, SETS - 1);
      if (op < 2)
        do_fill(w, s, $urandom, $urandom, $urandom, $urandom, op[0], $urandom_range(0, 1) == 1);
      else if (op < 3)
        b2b(w, s, rnd_line(), 16'($urandom));
      else if (op < 6)
        do_req(1, w, s, rnd_line(), ($urandom_range(0, 7) == 0) ? '0 : 16'($urandom), "rnd_wr");
      else
        do_req(0, w, s, '0, '0, "rnd_rd");
    end

    // Reset in the middle of a refill
    @(negedge clk);
    fill_start = 1; fill_way = 1; fill_index = 4;
    @(posedge clk); #1; fill_start = 0;
    for (int k = 0; k < 2; k++) begin
      fill_valid = 1; fill_data = 32'hB0 + k;
      @(posedge clk); #1;
    end
    rst_n = 0;
    @(posedge clk); #1;
    check("midrst.req_ready", req_ready, 0);
    check("midrst.fill_ready", fill_ready, 0);
    check("midrst.fill_done", fill_done, 0);
    check("midrst.rsp_valid", rsp_valid, 0);
    check("midrst.rsp_data", rsp_data, '0);
    @(posedge clk); #1;
    check("midrst.fill_done2", fill_done, 0);
    fill_valid = 0;
    rst_n = 1;
    clear_model();
    @(posedge clk); #1;
    check("midrst.fill_done3", fill_done, 0);
    check("midrst.idle", req_ready, 1);
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < SETS; s++)
        do_req(0, w, s, '0, '0, "midrst.clear");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
